// File: rtl/param_ext_decoder.sv
// param_ext_decoder
//   Receive-side partner of the parameterised blackbox adder. Each incoming
//   word carries bar = foo + OFFSET (mod 2^16). This block subtracts OFFSET
//   back out and compares the recovered foo against a running expected
//   sequence that starts at SEED. It counts mismatches and halts input once
//   the count reaches MAX_ERR. OFFSET is derived from the same parameter set
//   as the adder, so a wrong decode shows that a parameter value was lost
//   on its way to the external module.
//
// Ports
//   clock      in   1   rising-edge clock for all state
//   reset      in   1   synchronous, active-high; empties the FIFO and restarts checking
//   clear      in   1   synchronous pulse; restarts checking and keeps FIFO contents
//   in_valid   in   1   encoded word valid
//   in_ready   out  1   decoder can accept a word this cycle
//   in_bar     in   16  encoded word
//   out_valid  out  1   decoded word available at the FIFO head
//   out_ready  in   1   sink accepts the head word
//   out_foo    out  16  decoded word (in_bar - OFFSET, wrapping)
//   out_match  out  1   decoded word equalled the expected value when accepted
//   err_cnt    out  8   saturating mismatch count
//   state      out  2   0 IDLE, 1 RUN, 2 HALT

module param_ext_decoder #(
  parameter int          VALUE     = 0,
  parameter string       STRING    = "one",
  parameter real         REAL      = 1.0,
  parameter int          TYP_WIDTH = 1,
  parameter logic [15:0] SEED      = 16'h0000,
  parameter logic [7:0]  MAX_ERR   = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_bar,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_foo,
  output logic        out_match,
  output logic [7:0]  err_cnt,
  output logic [1:0]  state
);

  // Each parameter adds a small term to the offset. The string and the
  // real parameters are classified rather than used numerically, so that a
  // mangled value still gives a recognisably different offset.
  localparam int FIZZ = (STRING == "two") ? 2 : ((STRING == "one") ? 1 : 0);
  localparam int BUZZ = (REAL > 2.5E50) ? 2 : ((REAL < 0.0) ? 1 : 0);
  localparam int TPE  = (TYP_WIDTH > 1) ? 2 : 0;
  localparam int OFFSET_SUM = VALUE + FIZZ + BUZZ + TPE;
  localparam logic [15:0] OFFSET = OFFSET_SUM[15:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      fsm_state;
  logic [15:0] exp_val;
  logic [7:0]  err_reg;

  // Two-entry output FIFO: storage, pointers and occupancy
  logic [15:0] mem_foo [2];
  logic [1:0]  mem_match;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic        fifo_full;
  logic        accept;
  logic        pop;
  logic [15:0] dec_foo;
  logic        dec_match;
  logic [7:0]  err_next;

  assign dec_foo   = in_bar - OFFSET;
  assign dec_match = (dec_foo == exp_val);

  // in_ready does not look at out_ready. A full FIFO refuses input even
  // when the head is being drained in the same cycle. This keeps the
  // sink's ready signal off any combinational path to the source.
  assign fifo_full = (count == 2'd2);
  assign in_ready  = !fifo_full && (fsm_state != HALT) && !clear;
  assign accept    = in_valid && in_ready;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;

  assign out_foo   = mem_foo[rd_ptr];
  assign out_match = mem_match[rd_ptr];
  assign err_cnt   = err_reg;
  assign state     = fsm_state;

  // The mismatch counter holds at 255 instead of wrapping back to 0.
  assign err_next = (!dec_match && (err_reg != 8'hFF)) ? (err_reg + 8'd1) : err_reg;

  // FIFO bookkeeping. A push and a pop in the same cycle leave the
  // occupancy unchanged. The head only moves on a pop, so out_foo and
  // out_match stay stable while the sink stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_foo[0] <= 16'h0000;
      mem_foo[1] <= 16'h0000;
      mem_match  <= 2'b00;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      if (accept) begin
        mem_foo[wr_ptr]   <= dec_foo;
        mem_match[wr_ptr] <= dec_match;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (accept && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !accept) begin
        count <= count - 2'd1;
      end
    end
  end

  // Checker and FSM. clear takes priority but never coincides with an
  // accept, because in_ready is low during clear. The threshold test uses
  // the updated count, so HALT is entered on the same edge that records
  // the final mismatch.
  always_ff @(posedge clock) begin
    if (reset) begin
      exp_val   <= SEED;
      err_reg   <= 8'd0;
      fsm_state <= IDLE;
    end else if (clear) begin
      exp_val   <= SEED;
      err_reg   <= 8'd0;
      fsm_state <= IDLE;
    end else if (accept) begin
      exp_val <= exp_val + 16'd1;
      err_reg <= err_next;
      if ((MAX_ERR != 8'd0) && (err_next == MAX_ERR)) begin
        fsm_state <= HALT;
      end else begin
        fsm_state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_param_ext_decoder.sv
// tb_param_ext_decoder
//   Directed bench for param_ext_decoder. Five instances share one input
//   stream, and each instance has its own parameter set:
//     a: defaults (OFFSET 1, SEED 0, no halting)
//     b: SEED 0xFFFF
//     c: VALUE 10, "two", 3.0E50, TYP_WIDTH 8 (OFFSET 16)
//     d: VALUE 0, "x", -1.0, TYP_WIDTH 1 (OFFSET 1)
//     e: MAX_ERR 2
//   All instances are reset together between scenarios. Each scenario
//   checks only the instance whose parameters it targets.

module tb_param_ext_decoder;

  logic        clock;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_bar;
  logic        out_ready;

  logic        a_in_ready, b_in_ready, c_in_ready, d_in_ready, e_in_ready;
  logic        a_out_valid, b_out_valid, c_out_valid, d_out_valid, e_out_valid;
  logic [15:0] a_out_foo, b_out_foo, c_out_foo, d_out_foo, e_out_foo;
  logic        a_out_match, b_out_match, c_out_match, d_out_match, e_out_match;
  logic [7:0]  a_err_cnt, b_err_cnt, c_err_cnt, d_err_cnt, e_err_cnt;
  logic [1:0]  a_state, b_state, c_state, d_state, e_state;

  int tests_run;
  int tests_failed;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  param_ext_decoder dut_a (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_bar(in_bar),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_foo(a_out_foo),
    .out_match(a_out_match), .err_cnt(a_err_cnt), .state(a_state)
  );

  param_ext_decoder #(.SEED(16'hFFFF)) dut_b (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_bar(in_bar),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_foo(b_out_foo),
    .out_match(b_out_match), .err_cnt(b_err_cnt), .state(b_state)
  );

  param_ext_decoder #(.VALUE(10), .STRING("two"), .REAL(3.0E50), .TYP_WIDTH(8)) dut_c (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_bar(in_bar),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_foo(c_out_foo),
    .out_match(c_out_match), .err_cnt(c_err_cnt), .state(c_state)
  );

  param_ext_decoder #(.VALUE(0), .STRING("x"), .REAL(-1.0), .TYP_WIDTH(1)) dut_d (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(d_in_ready), .in_bar(in_bar),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_foo(d_out_foo),
    .out_match(d_out_match), .err_cnt(d_err_cnt), .state(d_state)
  );

  param_ext_decoder #(.MAX_ERR(8'd2)) dut_e (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(e_in_ready), .in_bar(in_bar),
    .out_valid(e_out_valid), .out_ready(out_ready), .out_foo(e_out_foo),
    .out_match(e_out_match), .err_cnt(e_err_cnt), .state(e_state)
  );

  // Drive one cycle of input, then settle 1ns past the rising edge so
  // that outputs are sampled away from the edge.
  task automatic applyStimulus(input logic valid, input logic [15:0] bar, input logic rdy);
    in_valid  = valid;
    in_bar    = bar;
    out_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic applyReset();
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_bar    = 16'h0000;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    clear        = 1'b0;
    in_valid     = 1'b0;
    in_bar       = 16'h0000;
    out_ready    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Values after reset
    checkOutput("rst_in_ready",  16'(a_in_ready),  16'd1);
    checkOutput("rst_out_valid", 16'(a_out_valid), 16'd0);
    checkOutput("rst_out_foo",   a_out_foo,        16'h0000);
    checkOutput("rst_out_match", 16'(a_out_match), 16'd0);
    checkOutput("rst_err_cnt",   16'(a_err_cnt),   16'd0);
    checkOutput("rst_state",     16'(a_state),     16'd0);

    // Scenario 1: default offset, streaming bar 1,2,3
    applyStimulus(1'b1, 16'd1, 1'b1);
    checkOutput("s1_valid0", 16'(a_out_valid), 16'd1);
    checkOutput("s1_foo0",   a_out_foo,        16'd0);
    checkOutput("s1_match0", 16'(a_out_match), 16'd1);
    applyStimulus(1'b1, 16'd2, 1'b1);
    checkOutput("s1_foo1",   a_out_foo,        16'd1);
    checkOutput("s1_match1", 16'(a_out_match), 16'd1);
    applyStimulus(1'b1, 16'd3, 1'b1);
    checkOutput("s1_foo2",   a_out_foo,        16'd2);
    checkOutput("s1_match2", 16'(a_out_match), 16'd1);
    checkOutput("s1_err",    16'(a_err_cnt),   16'd0);
    checkOutput("s1_state",  16'(a_state),     16'd1);
    applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("s1_drained", 16'(a_out_valid), 16'd0);

    // Scenario 2: decode wrap, and the expected-value wrap with SEED 0xFFFF
    applyReset();
    applyStimulus(1'b1, 16'h0000, 1'b1);
    checkOutput("s2_a_foo",   a_out_foo,        16'hFFFF);
    checkOutput("s2_a_match", 16'(a_out_match), 16'd0);
    checkOutput("s2_b_foo",   b_out_foo,        16'hFFFF);
    checkOutput("s2_b_match", 16'(b_out_match), 16'd1);
    applyStimulus(1'b1, 16'h0001, 1'b1);
    checkOutput("s2_b_foo2",   b_out_foo,        16'h0000);
    checkOutput("s2_b_match2", 16'(b_out_match), 16'd1);
    checkOutput("s2_b_err",    16'(b_err_cnt),   16'd0);
    checkOutput("s2_a_err",    16'(a_err_cnt),   16'd2);
    applyStimulus(1'b0, 16'd0, 1'b1);

    // Scenario 3: offset built from every parameter term
    applyReset();
    applyStimulus(1'b1, 16'd16, 1'b1);
    checkOutput("s3_c_foo",   c_out_foo,        16'd0);
    checkOutput("s3_c_match", 16'(c_out_match), 16'd1);
    checkOutput("s3_d_foo0",  d_out_foo,        16'd15);
    applyStimulus(1'b1, 16'd5, 1'b1);
    checkOutput("s3_d_foo",   d_out_foo,        16'd4);
    checkOutput("s3_c_wrap",  c_out_foo,        16'hFFF5);
    checkOutput("s3_c_match2", 16'(c_out_match), 16'd0);
    applyStimulus(1'b0, 16'd0, 1'b1);

    // Scenario 4: backpressure fills the FIFO, then it drains in order
    applyReset();
    applyStimulus(1'b1, 16'd1, 1'b0);
    checkOutput("s4_ready1", 16'(a_in_ready), 16'd1);
    applyStimulus(1'b1, 16'd2, 1'b0);
    checkOutput("s4_full_ready", 16'(a_in_ready),  16'd0);
    checkOutput("s4_valid",      16'(a_out_valid), 16'd1);
    checkOutput("s4_head",       a_out_foo,        16'd0);
    applyStimulus(1'b1, 16'd3, 1'b0);
    checkOutput("s4_hold_foo",   a_out_foo,        16'd0);
    checkOutput("s4_hold_ready", 16'(a_in_ready),  16'd0);
    applyStimulus(1'b1, 16'd3, 1'b1);
    checkOutput("s4_foo1",   a_out_foo,       16'd1);
    checkOutput("s4_ready2", 16'(a_in_ready), 16'd1);
    applyStimulus(1'b1, 16'd3, 1'b1);
    checkOutput("s4_foo2",   a_out_foo,        16'd2);
    checkOutput("s4_match2", 16'(a_out_match), 16'd1);
    applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("s4_empty", 16'(a_out_valid), 16'd0);

    // Scenario 5: error threshold halts input; clear restarts checking
    applyReset();
    applyStimulus(1'b1, 16'd9, 1'b1);
    checkOutput("s5_err1",   16'(e_err_cnt), 16'd1);
    checkOutput("s5_state1", 16'(e_state),   16'd1);
    applyStimulus(1'b1, 16'd9, 1'b1);
    checkOutput("s5_err2",     16'(e_err_cnt),   16'd2);
    checkOutput("s5_halt",     16'(e_state),     16'd2);
    checkOutput("s5_halt_rdy", 16'(e_in_ready),  16'd0);
    checkOutput("s5_drain_foo", e_out_foo,       16'd8);
    in_valid = 1'b0;
    clear    = 1'b1;
    #1;
    checkOutput("s5_clear_rdy", 16'(a_in_ready), 16'd0);
    @(posedge clock);
    #1;
    clear = 1'b0;
    #1;
    checkOutput("s5_clr_state", 16'(e_state),    16'd0);
    checkOutput("s5_clr_err",   16'(e_err_cnt),  16'd0);
    checkOutput("s5_clr_rdy",   16'(e_in_ready), 16'd1);

    // Scenario 6: reset while the FIFO is full
    applyReset();
    applyStimulus(1'b1, 16'd5, 1'b0);
    applyStimulus(1'b1, 16'd7, 1'b0);
    checkOutput("s6_full_rdy", 16'(a_in_ready), 16'd0);
    checkOutput("s6_err",      16'(a_err_cnt),  16'd2);
    applyReset();
    checkOutput("s6_valid", 16'(a_out_valid), 16'd0);
    checkOutput("s6_err0",  16'(a_err_cnt),   16'd0);
    checkOutput("s6_state", 16'(a_state),     16'd0);
    checkOutput("s6_rdy",   16'(a_in_ready),  16'd1);
    applyStimulus(1'b1, 16'd1, 1'b1);
    checkOutput("s6_foo",   a_out_foo,        16'd0);
    checkOutput("s6_match", 16'(a_out_match), 16'd1);
    applyStimulus(1'b0, 16'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
